// File: rtl/frame_pixel_streamer.sv
// Raster frame reader: walks a frame RAM row-major and emits a strobed pixel stream with blanking.
// Optional `TEST_PATTERN_EN adds i_pat_en, replacing RAM pixels with an (h+v) mod 256 ramp.
`timescale 1ns/1ps
module frame_pixel_streamer #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 32,
  parameter int ADDR_W     = 20,
  parameter int BASE_ADDR  = 0,
  parameter int CONTINUOUS = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
`ifdef TEST_PATTERN_EN
  input  logic              i_pat_en,
`endif
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic              o_en,
  output logic [7:0]        o_data,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_frame_done
);

  localparam int H_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int V_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int B_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int B_W   = (B_MAX > 1) ? $clog2(B_MAX) : 1;

  localparam logic [H_W-1:0]    H_LAST  = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0]    V_LAST  = V_W'(V_ACTIVE - 1);
  localparam logic [B_W-1:0]    HB_LAST = B_W'(H_BLANK - 1);
  localparam logic [B_W-1:0]    VB_LAST = B_W'(V_BLANK - 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [H_W-1:0]    h_cnt_q, h_cnt_d;
  logic [V_W-1:0]    v_cnt_q, v_cnt_d;
  logic [B_W-1:0]    blank_q, blank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              stop_q, stop_d;
  logic              pat_q, pat_d;
  logic              pat_req;
  logic              stop_now;

`ifdef TEST_PATTERN_EN
  assign pat_req = i_pat_en;
`else
  assign pat_req = 1'b0;
`endif

  // A stop pulse arriving on the very cycle of the VBLANK decision still counts.
  assign stop_now = stop_q | i_stop;

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    blank_d = blank_q;
    addr_d  = addr_q;
    stop_d  = stop_q;
    pat_d   = pat_q;
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (i_start) begin
          state_d = ST_ACTIVE;
          h_cnt_d = '0;
          v_cnt_d = '0;
          addr_d  = BASE;
          stop_d  = i_stop;
          pat_d   = pat_req;
        end
      end
      ST_ACTIVE: begin
        stop_d = stop_now;
        addr_d = addr_q + ADDR_W'(1);
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          blank_d = '0;
          state_d = ST_HBLANK;
        end else begin
          h_cnt_d = h_cnt_q + H_W'(1);
        end
      end
      ST_HBLANK: begin
        stop_d = stop_now;
        if (blank_q == HB_LAST) begin
          blank_d = '0;
          if (v_cnt_q != V_LAST) begin
            v_cnt_d = v_cnt_q + V_W'(1);
            state_d = ST_ACTIVE;
          end else begin
            v_cnt_d = '0;
            state_d = ST_VBLANK;
          end
        end else begin
          blank_d = blank_q + B_W'(1);
        end
      end
      ST_VBLANK: begin
        stop_d = stop_now;
        if (blank_q == VB_LAST) begin
          blank_d = '0;
          if ((CONTINUOUS != 0) && !stop_now) begin
            state_d = ST_ACTIVE;
            addr_d  = BASE;
            pat_d   = pat_req;
          end else begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end
        end else begin
          blank_d = blank_q + B_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      blank_q <= '0;
      addr_q  <= BASE;
      stop_q  <= 1'b0;
      pat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      blank_q <= blank_d;
      addr_q  <= addr_d;
      stop_q  <= stop_d;
      pat_q   <= pat_d;
    end
  end

  logic       active;
  logic       sof_c, eol_c, done_c;
  logic [7:0] pat_pix;

  assign active  = (state_q == ST_ACTIVE);
  assign sof_c   = active && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign eol_c   = active && (h_cnt_q == H_LAST);
  assign done_c  = eol_c && (v_cnt_q == V_LAST);
  assign pat_pix = 8'(h_cnt_q) + 8'(v_cnt_q);

  // Stage 1 runs alongside the RAM access; stage 2 is the output register.
  logic       s1_en_q, s1_sof_q, s1_eol_q, s1_done_q, s1_pat_q;
  logic [7:0] s1_pix_q;
  logic       en_q, sof_q, eol_q, done_q;
  logic [7:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (s1_en_q) begin
      data_d = s1_pat_q ? s1_pix_q : i_rd_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_en_q   <= 1'b0;
      s1_sof_q  <= 1'b0;
      s1_eol_q  <= 1'b0;
      s1_done_q <= 1'b0;
      s1_pat_q  <= 1'b0;
      s1_pix_q  <= '0;
      en_q      <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      s1_en_q   <= active;
      s1_sof_q  <= sof_c;
      s1_eol_q  <= eol_c;
      s1_done_q <= done_c;
      s1_pat_q  <= pat_q;
      s1_pix_q  <= pat_pix;
      en_q      <= s1_en_q;
      sof_q     <= s1_sof_q;
      eol_q     <= s1_eol_q;
      done_q    <= s1_done_q;
      data_q    <= data_d;
    end
  end

  assign o_busy       = (state_q != ST_IDLE);
  assign o_rd_en      = active && !pat_q;
  assign o_rd_addr    = addr_q;
  assign o_en         = en_q;
  assign o_data       = data_q;
  assign o_sof        = sof_q;
  assign o_eol        = eol_q;
  assign o_frame_done = done_q;

endmodule
